// File: rtl/corr_sequencer_pkg.sv
// Shared types and constants for the correlator sequencer.
// Holds the FSM state encoding, default sweep geometry and code-select values.
package corr_sequencer_pkg;

    localparam int CODE_LEN = 15;
    localparam int N_PHASES = 4;
    localparam int CHIP_W   = 4;
    localparam int PHASE_W  = 2;

    localparam logic CORR_REF  = 1'b0;
    localparam logic CORR_ORTH = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_SWEEP  = 3'd3,
        ST_RESULT = 3'd4
    } corr_state_t;

endpackage

// File: rtl/corr_sequencer_chip_counter.sv
// Chip address counter for one correlation sweep: load to 0, step while enabled,
// flag the last chip so the sequencer can leave the sweep.
module corr_chip_counter #(
    parameter int LEN = 15,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(LEN - 1);

    assign tc = (count == LAST);

    // wraps to 0 after the last chip so the address idles at 0 between sweeps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/corr_sequencer.sv
// Sequencer for a phase-banked Gold-code correlator: per sample it shifts one bank,
// then sweeps the reference and orthogonal codes and hands each result to a consumer.
module corr_sequencer #(
    parameter int CODE_LEN = corr_sequencer_pkg::CODE_LEN,
    parameter int N_PHASES = corr_sequencer_pkg::N_PHASES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       sample_stb,
    input  logic       ovr_clr,
    input  logic       res_ready,
    output logic       shift_en,
    output logic [1:0] phase,
    output logic [3:0] chip_idx,
    output logic       corr_sel,
    output logic       acc_clr,
    output logic       acc_en,
    output logic       res_valid,
    output logic       res_corr,
    output logic [1:0] res_phase,
    output logic       busy,
    output logic       overrun
);

    // state  | meaning
    // IDLE   | waiting for a sample (or a pending one) while enabled
    // SHIFT  | write the new sample into bank `phase`
    // CLEAR  | clear the shared accumulator, reset chip address
    // SWEEP  | accumulate CODE_LEN chips against the selected code
    // RESULT | present the result until the consumer takes it

    import corr_sequencer_pkg::*;

    localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(N_PHASES - 1);

    corr_state_t        state_q, state_d;
    logic               pending;
    logic               cnt_load, cnt_en, cnt_tc;
    logic [CHIP_W-1:0]  cnt;
    logic               start, handshake;

    corr_chip_counter #(
        .LEN (CODE_LEN),
        .W   (CHIP_W)
    ) u_chip_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .en    (cnt_en),
        .count (cnt),
        .tc    (cnt_tc)
    );

    assign start = enable && (sample_stb || pending);

    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        res_valid = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        handshake = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                state_d  = ST_CLEAR;
            end
            ST_CLEAR: begin
                acc_clr  = 1'b1;
                cnt_load = 1'b1;
                state_d  = ST_SWEEP;
            end
            ST_SWEEP: begin
                acc_en = 1'b1;
                cnt_en = 1'b1;
                if (cnt_tc) state_d = ST_RESULT;
            end
            ST_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    handshake = 1'b1;
                    state_d   = (corr_sel == CORR_REF) ? ST_CLEAR : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_sel <= CORR_REF;
            phase    <= '0;
        end else if (state_q == ST_SHIFT) begin
            corr_sel <= CORR_REF;
        end else if (handshake) begin
            if (corr_sel == CORR_REF) begin
                corr_sel <= CORR_ORTH;
            end else begin
                corr_sel <= CORR_REF;
                phase    <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            end
        end
    end

    // a strobe landing on the start edge together with a pending sample keeps it pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                if (start) pending <= sample_stb && pending;
            end else if (sample_stb && enable) begin
                pending <= 1'b1;
            end

            if (state_q != ST_IDLE && sample_stb && enable && pending) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign chip_idx  = (state_q == ST_SWEEP) ? cnt : '0;
    assign res_corr  = res_valid & corr_sel;
    assign res_phase = res_valid ? phase : '0;

endmodule

// File: tb/tb_corr_sequencer.sv
// Directed bench for corr_sequencer with hand-derived expectations per cycle.
module tb_corr_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       sample_stb = 1'b0;
    logic       ovr_clr = 1'b0;
    logic       res_ready = 1'b0;
    logic       shift_en;
    logic [1:0] phase;
    logic [3:0] chip_idx;
    logic       corr_sel;
    logic       acc_clr;
    logic       acc_en;
    logic       res_valid;
    logic       res_corr;
    logic [1:0] res_phase;
    logic       busy;
    logic       overrun;

    int n_chk  = 0;
    int n_fail = 0;

    corr_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sample_stb (sample_stb),
        .ovr_clr    (ovr_clr),
        .res_ready  (res_ready),
        .shift_en   (shift_en),
        .phase      (phase),
        .chip_idx   (chip_idx),
        .corr_sel   (corr_sel),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .res_valid  (res_valid),
        .res_corr   (res_corr),
        .res_phase  (res_phase),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [14:0] outs();
        return {busy, phase, shift_en, acc_clr, acc_en, res_valid,
                res_corr, res_phase, chip_idx, overrun};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; sample_stb = 1'b0; ovr_clr = 1'b0; res_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_stb();
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (res_valid !== 1'b1 && n < 200) begin tick(); n++; end
        chk_eq(tag, res_valid, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin tick(); n++; end
        chk_eq(tag, busy, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && ($countones({shift_en, acc_clr, acc_en, res_valid}) > 1))
            chk_eq("strobe_excl", {shift_en, acc_clr, acc_en, res_valid}, 0);
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] exp_v;
        logic        e_se, e_ac, e_ae, e_rv, e_rc;
        logic [3:0]  e_chip;
        int          n;

        // reset state
        rst_n = 1'b0;
        #2;
        chk_eq("reset_outs", outs(), 0);
        do_reset();
        chk_eq("post_reset_outs", outs(), 0);

        // single sample, cycle-accurate profile
        enable = 1'b1; res_ready = 1'b1; sample_stb = 1'b1;
        for (int c = 1; c <= 37; c++) begin
            tick();
            sample_stb = 1'b0;
            e_se   = (c == 1);
            e_ac   = (c == 2) || (c == 19);
            e_ae   = (c >= 3 && c <= 17) || (c >= 20 && c <= 34);
            e_rv   = (c == 18) || (c == 35);
            e_rc   = (c == 35);
            e_chip = !e_ae ? 4'd0 : (c <= 17) ? 4'(c - 3) : 4'(c - 20);
            exp_v  = {(c <= 35), ((c >= 36) ? 2'd1 : 2'd0), e_se, e_ac, e_ae, e_rv,
                      e_rc, 2'd0, e_chip, 1'b0};
            chk_eq($sformatf("seq1_c%0d", c), outs(), exp_v);
        end

        // four sequences, phase rotation and wrap
        do_reset();
        enable = 1'b1; res_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            pulse_stb();
            wait_valid("rot_v0");
            chk_eq($sformatf("rot_ref_p%0d", p), {res_corr, res_phase}, {1'b0, 2'(p)});
            tick();
            wait_valid("rot_v1");
            chk_eq($sformatf("rot_orth_p%0d", p), {res_corr, res_phase}, {1'b1, 2'(p)});
            wait_idle("rot_idle");
            chk_eq($sformatf("rot_next_p%0d", p), phase, (p + 1) % 4);
            repeat (3) tick();
        end
        chk_eq("rot_wrap", phase, 0);

        // back-pressure in RESULT
        do_reset();
        enable = 1'b1; res_ready = 1'b0;
        pulse_stb();
        wait_valid("bp_v0");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_eq($sformatf("bp_hold_%0d", i), {res_valid, res_corr, res_phase, acc_en, acc_clr},
                   {1'b1, 1'b0, 2'd0, 1'b0, 1'b0});
        end
        res_ready = 1'b1;
        tick();
        chk_eq("bp_release", {res_valid, acc_clr}, 2'b01);
        wait_valid("bp_v1");
        chk_eq("bp_orth", {res_corr, res_phase}, {1'b1, 2'd0});
        wait_idle("bp_idle");

        // pending and overrun
        do_reset();
        enable = 1'b1; res_ready = 1'b1;
        pulse_stb();
        repeat (4) tick();
        pulse_stb();
        chk_eq("pend_no_ovr", overrun, 0);
        repeat (4) tick();
        pulse_stb();
        chk_eq("ovr_set", overrun, 1);
        wait_idle("pend_idle1");
        tick();
        chk_eq("pend_runs", {shift_en, phase}, {1'b1, 2'd1});
        wait_idle("pend_idle2");
        repeat (3) tick();
        chk_eq("no_third", busy, 0);
        chk_eq("ovr_sticky", overrun, 1);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        chk_eq("ovr_clr", overrun, 0);

        // set wins over clear, then strobe on a pending start
        pulse_stb();
        tick(); tick();
        pulse_stb();
        sample_stb = 1'b1; ovr_clr = 1'b1;
        tick();
        sample_stb = 1'b0; ovr_clr = 1'b0;
        chk_eq("ovr_set_wins", overrun, 1);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        chk_eq("ovr_clr2", overrun, 0);
        wait_idle("coinc_idle");
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        chk_eq("coinc_start", {shift_en, overrun, phase}, {1'b1, 1'b0, 2'd3});
        wait_idle("coinc_idle2");
        tick();
        chk_eq("coinc_kept", {shift_en, phase}, {1'b1, 2'd0});
        wait_idle("coinc_idle3");
        repeat (3) tick();
        chk_eq("coinc_done", busy, 0);

        // async reset mid-sweep
        do_reset();
        enable = 1'b1; res_ready = 1'b1;
        pulse_stb();
        wait_valid("rst_pre_v0");
        tick();
        wait_valid("rst_pre_v1");
        wait_idle("rst_pre_idle");
        chk_eq("rst_pre_phase", phase, 1);
        pulse_stb();
        pulse_stb();
        pulse_stb();
        n = 0;
        while (!(acc_en && chip_idx == 4'd7) && n < 50) begin tick(); n++; end
        chk_eq("rst_at_chip7", {acc_en, chip_idx, overrun, corr_sel}, {1'b1, 4'd7, 1'b1, 1'b0});
        rst_n = 1'b0;
        #1;
        chk_eq("rst_async_outs", outs(), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq($sformatf("rst_hold_%0d", i), outs(), 0);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        chk_eq("rst_no_pending", {busy, overrun}, 2'b00);
        pulse_stb();
        enable = 1'b0;
        wait_valid("rst_post_v0");
        chk_eq("rst_post_ref", {res_corr, res_phase}, {1'b0, 2'd0});
        tick();
        wait_valid("rst_post_v1");
        chk_eq("rst_post_orth", {res_corr, res_phase}, {1'b1, 2'd0});
        wait_idle("rst_post_idle");
        chk_eq("rst_post_phase", phase, 1);

        // strobes ignored while disabled
        do_reset();
        enable = 1'b0; res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pulse_stb();
            chk_eq($sformatf("dis_%0d", i), {busy, overrun, shift_en}, 3'b000);
        end
        enable = 1'b1;
        repeat (3) tick();
        chk_eq("dis_no_pending", {busy, overrun}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/corr_sequencer.md
CORR_SEQUENCER -- requirements
Module: corr_sequencer

Interface
REQ-001 SHALL have parameter CODE_LEN, default 15, meaning Gold-code chips per correlation sweep.
REQ-002 SHALL have parameter N_PHASES, default 4, meaning sample phases (shift-register banks) per chip.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  permits starting new sequences.
REQ-006 SHALL have port sample_stb  input  1  one-cycle pulse, new sample available.
REQ-007 SHALL have port ovr_clr  input  1  clears the overrun flag.
REQ-008 SHALL have port res_ready  input  1  consumer accepts the presented result.
REQ-009 SHALL have port shift_en  output  1  write strobe into shift bank `phase`.
REQ-010 SHALL have port phase  output  2  current sample-phase bank index.
REQ-011 SHALL have port chip_idx  output  4  chip address into bank and code table.
REQ-012 SHALL have port corr_sel  output  1  0 = reference code, 1 = orthogonal code.
REQ-013 SHALL have port acc_clr  output  1  clears the shared sign-selector accumulator.
REQ-014 SHALL have port acc_en  output  1  accumulate enable for the shared accumulator.
REQ-015 SHALL have port res_valid  output  1  accumulator result is final.
REQ-016 SHALL have port res_corr  output  1  corr_sel of the presented result.
REQ-017 SHALL have port res_phase  output  2  phase of the presented result.
REQ-018 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-019 SHALL have port overrun  output  1  sticky flag, a sample was dropped.

Function
REQ-020 SHALL implement the FSM states IDLE, SHIFT, CLEAR, SWEEP and RESULT.
REQ-021 IDLE->SHIFT SHALL occur when enable=1 and either sample_stb=1 or pending=1; pending clears on that transition.
REQ-022 SHIFT SHALL last 1 cycle with shift_en=1, then go to CLEAR with corr_sel=0.
REQ-023 CLEAR SHALL last 1 cycle with acc_clr=1, then go to SWEEP with chip_idx=0.
REQ-024 SWEEP SHALL hold acc_en=1 for exactly CODE_LEN cycles, with chip_idx running 0..CODE_LEN-1, then go to RESULT.
REQ-025 RESULT SHALL assert res_valid with res_corr=corr_sel and res_phase=phase, holding all three stable until res_ready=1.
REQ-026 On the RESULT handshake with corr_sel=0, the block SHALL set corr_sel=1 and return to CLEAR.
REQ-027 On the RESULT handshake with corr_sel=1, the block SHALL go to IDLE and set phase to (phase+1) mod N_PHASES, wrapping 3->0.
REQ-028 Minimum sequence length SHALL be 35 cycles (SHIFT + 2x(CLEAR + 15 SWEEP + 1 RESULT)), with res_ready tied high.
REQ-029 A sample_stb arriving while busy=1 with enable=1 SHALL set pending; if pending is already 1, the sample SHALL be dropped and overrun set.
REQ-030 A sample_stb in IDLE coincident with pending=1 SHALL start one sequence, keep pending=1, and not set overrun.
REQ-031 A sample_stb arriving while enable=0 SHALL be ignored and SHALL NOT set pending or overrun.
REQ-032 Deasserting enable mid-sequence SHALL NOT abort the sequence; it only blocks the next IDLE->SHIFT.
REQ-033 ovr_clr SHALL clear overrun; if ovr_clr coincides with an overrun event, the set SHALL win.
REQ-034 shift_en, acc_clr, acc_en and res_valid SHALL be mutually exclusive in every cycle.
REQ-035 Outside SWEEP, chip_idx SHALL be 0.

Reset
REQ-036 rst_n=0 SHALL force the state to IDLE and clear phase, chip_idx, corr_sel, pending, overrun and all strobes immediately, without waiting for a clock edge.
REQ-037 A reset asserted mid-sequence SHALL discard the sequence with no res_valid; after release, the next sequence SHALL use phase 0.

Structure
REQ-038 A shared package SHALL hold the state enum, CODE_LEN, N_PHASES and the CORR_REF/CORR_ORTH constants.
REQ-039 The chip counter SHALL be a sub-module, corr_chip_counter (load, enable, terminal-count output).
REQ-040 Shift banks, code tables and the accumulator SHALL remain outside this block.

Verification
REQ-041 Reset, then a single sample_stb with res_ready=1 -> shift_en at cycle 1, acc_clr at cycles 2 and 19, acc_en for cycles 3-17 and 20-34, res_valid at cycles 18 and 35, phase=1 afterwards.
REQ-042 Four spaced strobes -> results reported with phases 0,1,2,3, then phase wraps to 0.
REQ-043 res_ready held low 10 cycles in RESULT -> res_valid, res_corr and res_phase stay stable, and no acc_en occurs during that time.
REQ-044 Three strobes within one sequence -> the second is pending and runs next; the third is dropped and sets overrun=1; ovr_clr then clears it.
REQ-045 rst_n pulsed low during SWEEP at chip 7 -> all outputs go to 0 asynchronously, with no res_valid; the next strobe runs with phase=0.
REQ-046 enable=0 with strobes applied -> busy stays 0, and pending and overrun stay 0.
